fetch_stage: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and drives a single-port instruction memory with a variable-latency done/stall handshake. It applies branch/jump redirects and halts, and presents the instruction, PC+2 and an error flag to IF/ID each cycle. When no valid instruction is available it presents the pipeline NOP (16'h0800) instead.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_hold_buf.sv | 39 +++
 rtl/fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and fetch state type
// Purpose: constants and types shared by the fetch stage, IF/ID and later stages.
//   NOP_INSTR : pipeline bubble encoding presented whenever no real slot exists
//   PC_INCR   : byte increment between sequential 16-bit instructions
//   fetch_state_e : fetch FSM states
package fetch_stage_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_INCR   = 16'd2;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry skid register for an instruction slot
// Purpose: captures one delivered slot (instr, pc+2, err) while the consumer stalls.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   load              : capture new_instr/new_pc2/new_err and set valid
//   clear             : drop the held slot (wins over load)
//   new_instr/new_pc2/new_err : slot to capture
//   valid/instr/pc2/err       : held slot
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] new_instr,
  input  logic [15:0] new_pc2,
  input  logic        new_err,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc2,
  output logic        err
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= 16'h0000;
      pc2   <= 16'h0000;
      err   <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= new_instr;
      pc2   <= new_pc2;
      err   <= new_err;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage feeding the IF/ID register
// Purpose: owns the PC, drives a variable-latency instruction memory, applies
// redirects and halts, and presents one slot (or the NOP bubble) to IF/ID.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   stall_in            : IF/ID hold request; a delivered slot is parked in the hold buffer
//   redirect/redirect_pc: taken branch/jump target pulse
//   halt                : stop fetching until reset
//   mem_rdata/mem_done/mem_stall/mem_err : memory response
//   mem_addr/mem_rd     : memory request (address is always the PC)
//   instruction_out/pc_plus_two_out/err_out : slot to IF/ID
//   fetch_busy          : no real slot this cycle
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] instruction_out,
  output logic [15:0] pc_plus_two_out,
  output logic        err_out,
  output logic        fetch_busy
);

  fetch_state_e state;
  logic [15:0]  pc;
  logic [15:0]  pc_inc;
  logic         pend_valid;
  logic [15:0]  pend_pc;
  // A halt seen while an access is outstanding must survive until it completes.
  logic         pend_halt;

  logic         hold_valid;
  logic [15:0]  hold_instr;
  logic [15:0]  hold_pc2;
  logic         hold_err;

  logic         rd_req;
  logic         new_slot;
  logic         show_hold;
  logic         flush_hold;
  logic [15:0]  slot_instr;
  logic         slot_err;
  logic         out_valid;

  assign pc_inc = pc + PC_INCR;

  // Decide what this cycle produces: a fresh slot, the held slot, or nothing.
  always_comb begin
    rd_req     = 1'b0;
    new_slot   = 1'b0;
    show_hold  = 1'b0;
    flush_hold = 1'b0;
    slot_instr = mem_rdata;
    slot_err   = mem_err;
    case (state)
      ST_FETCH: begin
        rd_req = !hold_valid && !halt && !pc[0];
        if (halt || redirect) begin
          flush_hold = 1'b1;
        end else if (hold_valid) begin
          show_hold = !stall_in;
        end else if (pc[0]) begin
          // Misaligned PC yields an error bubble instead of a memory access.
          new_slot   = 1'b1;
          slot_instr = NOP_INSTR;
          slot_err   = 1'b1;
        end else begin
          new_slot = mem_done && !mem_stall;
        end
      end
      ST_WAIT: begin
        rd_req   = 1'b1;
        new_slot = mem_done && !halt && !pend_halt && !redirect && !pend_valid;
      end
      default: ;
    endcase
  end

  assign mem_addr = pc;
  assign mem_rd   = rst_n && rd_req;

  always_comb begin
    out_valid       = 1'b0;
    instruction_out = NOP_INSTR;
    pc_plus_two_out = 16'h0000;
    err_out         = 1'b0;
    if (rst_n) begin
      if (show_hold) begin
        out_valid       = 1'b1;
        instruction_out = hold_instr;
        pc_plus_two_out = hold_pc2;
        err_out         = hold_err;
      end else if (new_slot && !stall_in) begin
        out_valid       = 1'b1;
        instruction_out = slot_instr;
        pc_plus_two_out = pc_inc;
        err_out         = slot_err;
      end
    end
  end

  // An error slot (even the misaligned NOP) counts as a delivered slot here.
  assign fetch_busy = !out_valid;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (new_slot && stall_in),
    .clear     (show_hold || flush_hold),
    .new_instr (slot_instr),
    .new_pc2   (pc_inc),
    .new_err   (slot_err),
    .valid     (hold_valid),
    .instr     (hold_instr),
    .pc2       (hold_pc2),
    .err       (hold_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= 16'h0000;
      pend_valid <= 1'b0;
      pend_pc    <= 16'h0000;
      pend_halt  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (halt) begin
            state <= ST_HALTED;
          end else if (redirect) begin
            pc <= redirect_pc;
          end else if (hold_valid) begin
            if (!stall_in && hold_err) state <= ST_HALTED;
          end else if (pc[0]) begin
            // PC stays put; an error parked in the hold buffer halts when presented.
            if (!stall_in) state <= ST_HALTED;
          end else if (mem_done && !mem_stall) begin
            pc <= pc_inc;
            if (mem_err && !stall_in) state <= ST_HALTED;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_done) begin
            pend_valid <= 1'b0;
            pend_halt  <= 1'b0;
            if (halt || pend_halt) begin
              state <= ST_HALTED;
            end else if (redirect) begin
              pc    <= redirect_pc;
              state <= ST_FETCH;
            end else if (pend_valid) begin
              pc    <= pend_pc;
              state <= ST_FETCH;
            end else begin
              pc    <= pc_inc;
              state <= (mem_err && !stall_in) ? ST_HALTED : ST_FETCH;
            end
          end else begin
            if (redirect) begin
              pend_valid <= 1'b1;
              pend_pc    <= redirect_pc;
            end
            if (halt) pend_halt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_err;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] instruction_out;
  logic [15:0] pc_plus_two_out;
  logic        err_out;
  logic        fetch_busy;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_in        (stall_in),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .mem_rdata       (mem_rdata),
    .mem_done        (mem_done),
    .mem_stall       (mem_stall),
    .mem_err         (mem_err),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .instruction_out (instruction_out),
    .pc_plus_two_out (pc_plus_two_out),
    .err_out         (err_out),
    .fetch_busy      (fetch_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order view of the fetch stream.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        err;
    logic        bubble;
  } slot_t;

  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_waiting;
  bit          m_pend_halt;
  bit          m_redir_pending;
  logic [15:0] m_redir_target;
  slot_t       m_held[$];

  logic [15:0] obs_instr, obs_pc2, obs_addr;
  logic        obs_err, obs_rd, obs_busy;

  task automatic model_reset();
    m_pc = 16'h0000;
    m_halted = 0;
    m_waiting = 0;
    m_pend_halt = 0;
    m_redir_pending = 0;
    m_redir_target = 16'h0000;
    m_held.delete();
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit rn, input bit st, input bit rdr, input logic [15:0] rpc,
                      input bit h, input bit d, input bit ms, input bit e,
                      input logic [15:0] rdat);
    bit          exp_rd;
    bit          have_out;
    bit          have_new;
    slot_t       out_s;
    slot_t       new_s;
    logic [15:0] exp_addr;
    logic [15:0] nxt;
    rst_n = rn; stall_in = st; redirect = rdr; redirect_pc = rpc; halt = h;
    mem_done = d; mem_stall = ms; mem_err = e; mem_rdata = rdat;
    @(negedge clk);
    exp_rd = 0; have_out = 0; have_new = 0;
    out_s = '0; new_s = '0;
    exp_addr = m_pc;
    nxt = m_pc + 16'd2;
    if (!rn) begin
      model_reset();
    end else if (!m_halted) begin
      if (m_waiting) begin
        exp_rd = 1;
        if (d) begin
          if (h || m_pend_halt) m_halted = 1;
          else if (rdr) m_pc = rpc;
          else if (m_redir_pending) m_pc = m_redir_target;
          else begin
            have_new = 1;
            new_s = '{rdat, nxt, e, 1'b0};
            m_pc = nxt;
          end
          m_waiting = 0; m_pend_halt = 0; m_redir_pending = 0;
        end else begin
          if (rdr) begin m_redir_pending = 1; m_redir_target = rpc; end
          if (h) m_pend_halt = 1;
        end
      end else begin
        exp_rd = (m_held.size() == 0) && !h && !m_pc[0];
        if (h) begin
          m_halted = 1; m_held.delete();
        end else if (rdr) begin
          m_pc = rpc; m_held.delete();
        end else if (m_held.size() != 0) begin
          if (!st) begin
            have_out = 1;
            out_s = m_held.pop_front();
            if (out_s.err) m_halted = 1;
          end
        end else if (m_pc[0]) begin
          have_new = 1;
          new_s = '{NOP, nxt, 1'b1, 1'b1};
        end else if (d && !ms) begin
          have_new = 1;
          new_s = '{rdat, nxt, e, 1'b0};
          m_pc = nxt;
        end else begin
          m_waiting = 1;
        end
      end
      if (have_new) begin
        if (st) m_held.push_back(new_s);
        else begin
          have_out = 1;
          out_s = new_s;
          if (new_s.err) m_halted = 1;
        end
      end
    end
    obs_instr = instruction_out; obs_pc2 = pc_plus_two_out; obs_addr = mem_addr;
    obs_err = err_out; obs_rd = mem_rd; obs_busy = fetch_busy;
    check("mem_rd", 16'(mem_rd), 16'(exp_rd));
    if (exp_rd) check("mem_addr", mem_addr, exp_addr);
    check("instr", instruction_out, have_out ? out_s.instr : NOP);
    check("pc2", pc_plus_two_out, have_out ? out_s.pc2 : 16'h0000);
    check("err", 16'(err_out), have_out ? 16'(out_s.err) : 16'h0000);
    if (!(have_out && out_s.bubble)) check("busy", 16'(fetch_busy), 16'(!have_out));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    bit          rn, st, rdr, h, d, ms, e;
    logic [15:0] rpc;
    model_reset();
    rst_n = 0; stall_in = 0; redirect = 0; redirect_pc = 0; halt = 0;
    mem_rdata = 0; mem_done = 0; mem_stall = 0; mem_err = 0;
    @(posedge clk);
    #1;

    // Reset values
    do_reset();
    check("rst_rd", 16'(obs_rd), 16'h0);
    check("rst_instr", obs_instr, NOP);
    check("rst_busy", 16'(obs_busy), 16'h1);
    check("rst_pc2", obs_pc2, 16'h0);

    // Zero-wait fetches
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'hA001);
    check("zw_addr0", obs_addr, 16'h0000);
    check("zw_instr0", obs_instr, 16'hA001);
    check("zw_pc2_0", obs_pc2, 16'h0002);
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'hA002);
    check("zw_addr1", obs_addr, 16'h0002);
    check("zw_instr1", obs_instr, 16'hA002);
    check("zw_pc2_1", obs_pc2, 16'h0004);
    step(1, 0, 0, 16'h0, 0, 0, 1, 0, 16'h0);
    check("zw_addr2", obs_addr, 16'h0004);

    // Three wait states at address 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("ws_addr", obs_addr, 16'h0000);
      check("ws_busy", 16'(obs_busy), 16'h1);
    end
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'hC3C3);
    check("ws_addr3", obs_addr, 16'h0000);
    check("ws_instr", obs_instr, 16'hC3C3);
    check("ws_pc2", obs_pc2, 16'h0002);

    // Stall while a word completes
    step(1, 1, 0, 16'h0, 0, 1, 0, 0, 16'hB0B0);
    check("st_nop", obs_instr, NOP);
    step(1, 1, 0, 16'h0, 0, 0, 0, 0, 16'h0);
    check("st_no_rd", 16'(obs_rd), 16'h0);
    idle();
    check("st_instr", obs_instr, 16'hB0B0);
    check("st_pc2", obs_pc2, 16'h0004);
    idle();
    check("st_once", 16'(obs_busy), 16'h1);

    // Redirects during WAIT
    step(1, 0, 1, 16'h0010, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'hDEAD);
    check("rw_discard0", 16'(obs_busy), 16'h1);
    idle();
    check("rw_addr10", obs_addr, 16'h0010);
    step(1, 0, 1, 16'h0040, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'hDEAD);
    check("rw_discard1", obs_instr, NOP);
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'h1234);
    check("rw_addr40", obs_addr, 16'h0040);
    check("rw_instr", obs_instr, 16'h1234);
    check("rw_pc2", obs_pc2, 16'h0042);

    // Misaligned target
    step(1, 0, 1, 16'h0041, 0, 0, 0, 0, 16'h0);
    idle();
    check("mis_err", 16'(obs_err), 16'h1);
    check("mis_pc2", obs_pc2, 16'h0043);
    check("mis_rd", 16'(obs_rd), 16'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("halted_rd", 16'(obs_rd), 16'h0);
    end

    // Memory error
    do_reset();
    step(1, 0, 0, 16'h0, 0, 1, 0, 1, 16'h5555);
    check("me_err", 16'(obs_err), 16'h1);
    check("me_instr", obs_instr, 16'h5555);
    idle();
    check("me_halted", 16'(obs_rd), 16'h0);

    // PC wrap
    do_reset();
    step(1, 0, 1, 16'hFFFE, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'h7777);
    check("wrap_addr", obs_addr, 16'hFFFE);
    check("wrap_pc2", obs_pc2, 16'h0000);
    check("wrap_err", 16'(obs_err), 16'h0);
    step(1, 0, 0, 16'h0, 0, 1, 0, 0, 16'h8888);
    check("wrap_next", obs_addr, 16'h0000);

    // Reset during WAIT
    do_reset();
    step(1, 0, 1, 16'h0020, 0, 0, 0, 0, 16'h0);
    idle();
    check("rwt_addr", obs_addr, 16'h0020);
    do_reset();
    idle();
    check("rwt_restart", obs_addr, 16'h0000);
    check("rwt_rd", 16'(obs_rd), 16'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rn  = !(($urandom % 300) == 0) && !(m_halted && ($urandom % 8) == 0);
      st  = ($urandom % 4) == 0;
      rdr = ($urandom % 10) == 0;
      case ($urandom % 12)
        0:       rpc = 16'hFFFE;
        1:       rpc = 16'($urandom) | 16'h0001;
        default: rpc = 16'($urandom) & 16'hFFFE;
      endcase
      h   = ($urandom % 150) == 0;
      d   = ($urandom % 2) == 0;
      ms  = !d && (($urandom % 2) == 0);
      e   = d && (($urandom % 40) == 0);
      step(rn, st, rdr, rpc, h, d, ms, e, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
